zbus_cycle_gen: RTL and testbench

Z80-style bus-cycle initiator: turns a single command handshake into a timed ZX-bus memory or I/O read/write cycle on `za`/`zd`/`zmreq_n`/`ziorq_n`/`zrd_n`/`zwr_n`, honours `zwait_n`, and returns read data. It is the master-side counterpart of the card's bus-slave decoder. It drives the same ZX-bus pins in FPGA test rigs and bench harnesses, so that port mapping, ROM-window mapping and W5300/SL811 strobe buffering can be exercised with real cycle timing.

---
 rtl/zbus_pkg.sv | 87 ++++++++
 rtl/zbus_cycle_gen_if.sv | 37 +++
 rtl/zbus_halft_ctr.sv | 43 ++++
 rtl/zbus_cycle_gen.sv | 164 ++++++++++++++++
 tb/tb_zbus_cycle_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/zbus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zbus_pkg : shared states, per-cycle-type half-T indices, strobe decode   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package zbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } zbus_state_e;

    typedef logic [3:0] halft_t;

    localparam halft_t MEM_HALFTS  = 4'd6;
    localparam halft_t IO_HALFTS   = 4'd8;
    localparam halft_t MEM_STB_ON  = 4'd1;
    localparam halft_t MEM_STB_OFF = 4'd5;
    localparam halft_t MEM_WR_ON   = 4'd3;
    localparam halft_t MEM_WAIT_N  = 4'd3;
    localparam halft_t MEM_LATCH_N = 4'd4;
    localparam halft_t IO_STB_ON   = 4'd2;
    localparam halft_t IO_STB_OFF  = 4'd7;
    localparam halft_t IO_WAIT_N   = 4'd5;
    localparam halft_t IO_LATCH_N  = 4'd6;
    localparam halft_t OE_ON       = 4'd1;

    typedef struct packed {
        logic mreq_n;
        logic iorq_n;
        logic rd_n;
        logic wr_n;
        logic oe;
    } zbus_stb_t;

    localparam zbus_stb_t STB_IDLE = '{mreq_n: 1'b1, iorq_n: 1'b1, rd_n: 1'b1,
                                       wr_n: 1'b1, oe: 1'b0};

    function automatic int unsigned halft_clks(input int unsigned t_clks);
        return t_clks / 2;
    endfunction

    function automatic halft_t last_idx(input logic io);
        return io ? (IO_HALFTS - 4'd1) : (MEM_HALFTS - 4'd1);
    endfunction

    function automatic halft_t wait_idx(input logic io);
        return io ? IO_WAIT_N : MEM_WAIT_N;
    endfunction

    function automatic halft_t latch_idx(input logic io);
        return io ? IO_LATCH_N : MEM_LATCH_N;
    endfunction

    function automatic zbus_stb_t stb_at(input logic io, input logic wr, input halft_t n);
        zbus_stb_t s;
        logic      on;
        s = STB_IDLE;
        if (io) begin
            on       = (n >= IO_STB_ON) && (n < IO_STB_OFF);
            s.iorq_n = !on;
            s.rd_n   = !(on && !wr);
            s.wr_n   = !(on && wr);
        end else begin
            on       = (n >= MEM_STB_ON) && (n < MEM_STB_OFF);
            s.mreq_n = !on;
            s.rd_n   = !(on && !wr);
            s.wr_n   = !(wr && (n >= MEM_WR_ON) && (n < MEM_STB_OFF));
        end
        s.oe = wr && (n >= OE_ON);
        return s;
    endfunction

    // The I/O cycle's built-in wait state occupies n=4..5.
    function automatic zbus_state_e state_at(input logic io, input halft_t n, input logic ins);
        if (ins)                    return ST_TW;
        else if (n < 4'd2)          return ST_T1;
        else if (n < 4'd4)          return ST_T2;
        else if (io && (n < 4'd6))  return ST_TW;
        else                        return ST_T3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zbus_cycle_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zbus_cycle_gen_if : command/response handshake and ZX-bus pin bundle     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface zbus_cycle_gen_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_io;
    logic        cmd_wr;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] za;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic [7:0]  zd_in;
    logic        zmreq_n;
    logic        ziorq_n;
    logic        zrd_n;
    logic        zwr_n;
    logic        zwait_n;

    modport master (
        input  cmd_valid, cmd_io, cmd_wr, cmd_addr, cmd_wdata, zd_in, zwait_n,
        output cmd_ready, rsp_valid, rsp_rdata, za, zd_out, zd_oe,
               zmreq_n, ziorq_n, zrd_n, zwr_n
    );

    modport slave (
        output cmd_valid, cmd_io, cmd_wr, cmd_addr, cmd_wdata, zd_in, zwait_n,
        input  cmd_ready, rsp_valid, rsp_rdata, za, zd_out, zd_oe,
               zmreq_n, ziorq_n, zrd_n, zwr_n
    );
endinterface
`default_nettype wire

// File: rtl/zbus_halft_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zbus_halft_ctr : fclk counter within one half-T, ticks every H fclk      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module zbus_halft_ctr #(
    parameter int unsigned H = 2
) (
    input  wire logic fclk,
    input  wire logic rst_n,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      last_o,
    output logic      nxt_last_o
);
    localparam int unsigned      CW      = (H > 1) ? $clog2(H) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(H - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    assign last_o = en_i && !clr_i && (cnt_q == CNT_MAX);
    // Lets the owner register an output that must be high exactly on a half-T's final fclk.
    assign nxt_last_o = (cnt_d == CNT_MAX);

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/zbus_cycle_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zbus_cycle_gen : Z80-style ZX-bus memory/I-O cycle initiator             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module zbus_cycle_gen
    import zbus_pkg::*;
#(
    parameter int unsigned T_CLKS = 4
) (
    input  wire logic          fclk,
    input  wire logic          rst_n,
    zbus_cycle_gen_if.master   bus
);
    localparam int unsigned H = halft_clks(T_CLKS);

    zbus_state_e state_q, state_d;
    halft_t      n_q, n_d;
    logic        ins_q, ins_d;
    logic        wt_q, wt_d;
    logic        io_q, io_d;
    logic        wr_q, wr_d;
    logic [15:0] za_q, za_d;
    logic [7:0]  zd_out_q, zd_out_d;
    zbus_stb_t   stb_q, stb_d;
    logic [7:0]  rd_q, rd_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic w_accept;
    logic w_last;
    logic w_nxt_last;
    logic w_end;
    logic w_lat;

    assign w_accept = bus.cmd_valid && cmd_ready_q;

    zbus_halft_ctr #(.H(H)) u_halft_ctr (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .clr_i      (w_accept),
        .en_i       (state_q != ST_IDLE),
        .last_o     (w_last),
        .nxt_last_o (w_nxt_last)
    );

    always_comb begin
        n_d   = n_q;
        ins_d = ins_q;
        wt_d  = wt_q;
        io_d  = io_q;
        wr_d  = wr_q;
        w_end = 1'b0;
        w_lat = 1'b0;

        if (state_q == ST_IDLE) begin
            if (w_accept) begin
                n_d   = '0;
                ins_d = 1'b0;
                wt_d  = 1'b0;
                io_d  = bus.cmd_io;
                wr_d  = bus.cmd_wr;
            end
        end else if (w_last) begin
            w_lat = !ins_q && !wr_q && (n_q == latch_idx(io_q));
            if (ins_q) begin
                // n stays parked on the sample index while inserted waits run.
                if (!wt_q) begin
                    wt_d = 1'b1;
                end else if (bus.zwait_n) begin
                    ins_d = 1'b0;
                    wt_d  = 1'b0;
                    n_d   = n_q + 4'd1;
                end else begin
                    wt_d = 1'b0;
                end
            end else if ((n_q == wait_idx(io_q)) && !bus.zwait_n) begin
                ins_d = 1'b1;
                wt_d  = 1'b0;
            end else if (n_q == last_idx(io_q)) begin
                w_end = 1'b1;
                n_d   = '0;
            end else begin
                n_d = n_q + 4'd1;
            end
        end

        if (((state_q == ST_IDLE) && !w_accept) || w_end) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_at(io_d, n_d, ins_d);
        end
    end

    always_comb begin
        za_d        = za_q;
        zd_out_d    = zd_out_q;
        stb_d       = STB_IDLE;
        rd_d        = w_lat ? bus.zd_in : rd_q;
        cmd_ready_d = (state_q == ST_IDLE) && !w_accept;

        if (w_accept) begin
            za_d = bus.cmd_addr;
            if (bus.cmd_wr) begin
                zd_out_d = bus.cmd_wdata;
            end
        end else if (state_d == ST_IDLE) begin
            za_d = '0;
        end

        if (state_d != ST_IDLE) begin
            stb_d = ins_d ? stb_q : stb_at(io_d, wr_d, n_d);
        end

        rsp_valid_d = (state_q != ST_IDLE) && (state_d != ST_IDLE) && !ins_d &&
                      (n_d == last_idx(io_q)) && w_nxt_last;
        rsp_rdata_d = (rsp_valid_d && !wr_q) ? rd_d : rsp_rdata_q;
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            ins_q       <= 1'b0;
            wt_q        <= 1'b0;
            io_q        <= 1'b0;
            wr_q        <= 1'b0;
            za_q        <= '0;
            zd_out_q    <= '0;
            stb_q       <= STB_IDLE;
            rd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            ins_q       <= ins_d;
            wt_q        <= wt_d;
            io_q        <= io_d;
            wr_q        <= wr_d;
            za_q        <= za_d;
            zd_out_q    <= zd_out_d;
            stb_q       <= stb_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.za        = za_q;
    assign bus.zd_out    = zd_out_q;
    assign bus.zd_oe     = stb_q.oe;
    assign bus.zmreq_n   = stb_q.mreq_n;
    assign bus.ziorq_n   = stb_q.iorq_n;
    assign bus.zrd_n     = stb_q.rd_n;
    assign bus.zwr_n     = stb_q.wr_n;
endmodule
`default_nettype wire

// File: tb/tb_zbus_cycle_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_zbus_cycle_gen : directed bus-cycle checks for zbus_cycle_gen         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_zbus_cycle_gen;
    logic fclk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 fclk = ~fclk;

    zbus_cycle_gen_if bus();

    zbus_cycle_gen #(.T_CLKS(4)) dut (
        .fclk  (fclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // fclk k = the k-th fclk after acceptance (k=0 is the first T1 fclk); sampled at negedge.
    task automatic run_cycle(input string name, input logic io, input logic wr,
                             input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] rd,
                             input int wait_k, input int bus_lo, input int bus_hi,
                             input int rw_lo, input int rw_hi, input int oe_lo, input int oe_hi,
                             input int rsp_k, input bit noise);
        int  guard;
        bit  inw, inrw, inoe;
        @(negedge fclk);
        bus.cmd_io    = io;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge fclk);
            guard++;
        end
        chk({name, ":ready_before"}, 32'(bus.cmd_ready), 32'd1);
        for (int k = 0; k <= rsp_k + 1; k++) begin
            @(negedge fclk);
            bus.cmd_valid = (noise && k <= rsp_k) ? ((k % 2) == 1) : 1'b0;
            if (noise) bus.cmd_addr = 16'($urandom);
            bus.zwait_n = (k == wait_k) ? 1'b0 : 1'b1;
            bus.zd_in   = (k >= rw_lo && k <= rw_hi) ? rd : ~rd;
            inw  = (k >= bus_lo) && (k <= bus_hi);
            inrw = (k >= rw_lo) && (k <= rw_hi);
            inoe = wr && (k >= oe_lo) && (k <= oe_hi);
            chk($sformatf("%s:mreq_n@%0d", name, k), 32'(bus.zmreq_n), 32'(!(inw && !io)));
            chk($sformatf("%s:iorq_n@%0d", name, k), 32'(bus.ziorq_n), 32'(!(inw && io)));
            chk($sformatf("%s:rd_n@%0d", name, k), 32'(bus.zrd_n), 32'(!(inrw && !wr)));
            chk($sformatf("%s:wr_n@%0d", name, k), 32'(bus.zwr_n), 32'(!(inrw && wr)));
            chk($sformatf("%s:zd_oe@%0d", name, k), 32'(bus.zd_oe), 32'(inoe));
            if (inoe) chk($sformatf("%s:zd_out@%0d", name, k), 32'(bus.zd_out), 32'(wd));
            chk($sformatf("%s:rsp_valid@%0d", name, k), 32'(bus.rsp_valid), 32'(k == rsp_k));
            chk($sformatf("%s:za@%0d", name, k), 32'(bus.za), (k <= rsp_k) ? 32'(addr) : 32'd0);
            chk($sformatf("%s:cmd_ready@%0d", name, k), 32'(bus.cmd_ready), 32'd0);
            if (k == rsp_k && !wr) chk({name, ":rsp_rdata"}, 32'(bus.rsp_rdata), 32'(rd));
        end
        @(negedge fclk);
        bus.zwait_n = 1'b1;
        chk({name, ":ready_after"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        int rdyk;
        int guard;
        int rsp_seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_io    = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.zd_in     = '0;
        bus.zwait_n   = 1'b1;

        repeat (2) @(negedge fclk);
        chk("rst:mreq_n", 32'(bus.zmreq_n), 32'd1);
        chk("rst:iorq_n", 32'(bus.ziorq_n), 32'd1);
        chk("rst:rd_n", 32'(bus.zrd_n), 32'd1);
        chk("rst:wr_n", 32'(bus.zwr_n), 32'd1);
        chk("rst:zd_oe", 32'(bus.zd_oe), 32'd0);
        chk("rst:za", 32'(bus.za), 32'd0);
        chk("rst:zd_out", 32'(bus.zd_out), 32'd0);
        chk("rst:rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst:rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst:cmd_ready", 32'(bus.cmd_ready), 32'd1);
        rst_n = 1'b1;

        //          name     io    wr    addr      wd     rd     wk  bus     rw      oe      rsp noise
        run_cycle("mrd",   1'b0, 1'b0, 16'h4000, 8'h00, 8'h5A, -1,  2,  9,  2,  9,  0,  0, 11, 1'b0);
        run_cycle("mrd_nw",1'b0, 1'b0, 16'h8001, 8'h00, 8'hE7,  4,  2,  9,  2,  9,  0,  0, 11, 1'b0);
        run_cycle("iowr",  1'b1, 1'b1, 16'h83AB, 8'hC3, 8'h00, -1,  4, 13,  4, 13,  2, 15, 15, 1'b0);
        chk("iowr:zd_out_hold", 32'(bus.zd_out), 32'hC3);
        chk("iowr:zd_oe_idle", 32'(bus.zd_oe), 32'd0);
        run_cycle("iord_w",1'b1, 1'b0, 16'h00FE, 8'h00, 8'h3C, 11,  4, 17,  4, 17,  0,  0, 19, 1'b0);
        run_cycle("mwr_nz",1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00, -1,  2,  9,  6,  9,  2, 11, 11, 1'b1);
        chk("mwr:rdata_hold", 32'(bus.rsp_rdata), 32'h3C);

        // Back-to-back: write then read with cmd_valid held high throughout.
        @(negedge fclk);
        bus.cmd_io    = 1'b0;
        bus.cmd_wr    = 1'b1;
        bus.cmd_addr  = 16'h2222;
        bus.cmd_wdata = 8'h99;
        bus.zd_in     = 8'h77;
        bus.cmd_valid = 1'b1;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge fclk);
            guard++;
        end
        rdyk = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge fclk);
            if (k == 0) begin
                bus.cmd_wr   = 1'b0;
                bus.cmd_addr = 16'h3333;
            end
            if (rdyk >= 0 && k == rdyk + 1) bus.cmd_valid = 1'b0;
            if (k == 6)  chk("b2b:wr_n@6", 32'(bus.zwr_n), 32'd0);
            if (k == 11) chk("b2b:rsp1@11", 32'(bus.rsp_valid), 32'd1);
            if (k == 12) chk("b2b:ready@12", 32'(bus.cmd_ready), 32'd0);
            if (k == 13) chk("b2b:za@13", 32'(bus.za), 32'd0);
            if (k == 14) chk("b2b:za@14", 32'(bus.za), 32'h3333);
            if (k == 16) chk("b2b:mreq_n@16", 32'(bus.zmreq_n), 32'd0);
            if (k == 16) chk("b2b:rd_n@16", 32'(bus.zrd_n), 32'd0);
            if (k == 25) chk("b2b:rsp2@25", 32'(bus.rsp_valid), 32'd1);
            if (k == 25) chk("b2b:rdata@25", 32'(bus.rsp_rdata), 32'h77);
            if (bus.cmd_ready && rdyk < 0) rdyk = k;
        end
        chk("b2b:ready_at", 32'(rdyk), 32'd13);

        // Reset asserted during a memory write.
        @(negedge fclk);
        bus.cmd_wr    = 1'b1;
        bus.cmd_addr  = 16'h5555;
        bus.cmd_wdata = 8'h11;
        bus.cmd_valid = 1'b1;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge fclk);
            guard++;
        end
        for (int k = 0; k <= 5; k++) begin
            @(negedge fclk);
            bus.cmd_valid = 1'b0;
        end
        chk("rstmid:mreq_n_before", 32'(bus.zmreq_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstmid:mreq_n", 32'(bus.zmreq_n), 32'd1);
        chk("rstmid:wr_n", 32'(bus.zwr_n), 32'd1);
        chk("rstmid:zd_oe", 32'(bus.zd_oe), 32'd0);
        chk("rstmid:za", 32'(bus.za), 32'd0);
        chk("rstmid:cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (3) @(negedge fclk);
        rst_n = 1'b1;
        rsp_seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge fclk);
            if (bus.rsp_valid) rsp_seen++;
        end
        chk("rstmid:no_rsp", 32'(rsp_seen), 32'd0);
        chk("rstmid:ready_after", 32'(bus.cmd_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
